seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_driver_if.sv | 31 +++
 rtl/seg7_digit_lut.sv | 28 ++
 rtl/seg7_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] DASH = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // 10^n evaluated at elaboration; 10^8 still fits comfortably in 64 bits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/load handshake and display outputs of the scan driver.
// master = value producer side, slave = the driver itself.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IN_W       = 14
);
    logic [IN_W-1:0]       value_in;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] digit_en;

    modport master (
        output value_in,
        output load,
        input  busy,
        input  overflow,
        input  seg,
        input  digit_en
    );

    modport slave (
        input  value_in,
        input  load,
        output busy,
        output overflow,
        output seg,
        output digit_en
    );
endinterface

// File: rtl/seg7_digit_lut.sv
// Nibble to 7-segment pattern decoder; purely combinational.
// 0-9 map to digits, DASH to a centre bar, anything else is dark.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            DASH:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double-dabble) display driver with multiplexed digit scan.
// Display updates IN_W+2 cycles after an accepted load; loads while busy are dropped.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IN_W       = 14,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    localparam int          BW    = 4 * NUM_DIGITS;
    localparam int          CW    = $clog2(IN_W + 1);
    localparam int          PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          XW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    state_t          state, state_nxt;
    logic [IN_W-1:0] bin_q, bin_nxt;
    logic [BW-1:0]   bcd_q, bcd_nxt, bcd_adj;
    logic [BW-1:0]   disp_q, disp_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            pend_q, pend_nxt;
    logic            ovf_q, ovf_nxt;

    logic [PW-1:0]       pre_q;
    logic [XW-1:0]       idx_q;
    logic [NUM_DIGITS:0] lz;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic [6:0]          lut_seg;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        bcd_nxt   = bcd_q;
        cnt_nxt   = cnt_q;
        pend_nxt  = pend_q;
        disp_nxt  = disp_q;
        ovf_nxt   = ovf_q;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    bin_nxt   = bus.value_in;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    pend_nxt  = (64'(bus.value_in) >= LIMIT);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // The cycle that finds all IN_W shifts done only hands over to COMMIT.
                if (cnt_q == CW'(IN_W)) begin
                    state_nxt = COMMIT;
                end else begin
                    bcd_nxt = {bcd_adj[BW-2:0], bin_q[IN_W-1]};
                    bin_nxt = bin_q << 1;
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                disp_nxt  = pend_q ? {NUM_DIGITS{DASH}} : bcd_q;
                ovf_nxt   = pend_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            bin_q  <= bin_nxt;
            bcd_q  <= bcd_nxt;
            cnt_q  <= cnt_nxt;
            pend_q <= pend_nxt;
            disp_q <= disp_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    // Scan timing free-runs regardless of conversions in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == XW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // lz[i] is set when digit i and everything above it are zero.
    always_comb begin
        lz             = '0;
        lz[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz[i] = lz[i+1] & (disp_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == XW'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = (BLANK_LZ != 0) && (i != 0) && lz[i];
            end
        end
    end

    seg7_digit_lut u_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf_q;
    assign bus.digit_en = NUM_DIGITS'(1) << idx_q;
    assign bus.seg      = cur_blank ? SEG_BLANK : lut_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: two drivers (blanking on/off) fed the same loads, scan observed per digit.
// Expected segment patterns are hand-written constants.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int IW = 14;
    localparam int SD = 4;

    localparam logic [6:0] P0   = 7'b0111111;
    localparam logic [6:0] P1   = 7'b0000110;
    localparam logic [6:0] P2   = 7'b1011011;
    localparam logic [6:0] P3   = 7'b1001111;
    localparam logic [6:0] P4   = 7'b1100110;
    localparam logic [6:0] P7   = 7'b0000111;
    localparam logic [6:0] P9   = 7'b1100111;
    localparam logic [6:0] PDSH = 7'b1000000;
    localparam logic [6:0] POFF = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [IW-1:0] value_in = '0;
    int            total = 0;
    int            bad = 0;
    int            cyc;
    int            rises;
    logic          prev_busy;
    logic [6:0]    exp0[4];
    logic [6:0]    exp1[4];

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND), .IN_W(IW)) bus0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(ND), .IN_W(IW)) bus1 ();

    assign bus0.value_in = value_in;
    assign bus0.load     = load;
    assign bus1.value_in = value_in;
    assign bus1.load     = load;

    seg7_scan_driver #(.NUM_DIGITS(ND), .IN_W(IW), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seg7_scan_driver #(.NUM_DIGITS(ND), .IN_W(IW), .SCAN_DIV(SD), .BLANK_LZ(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        value_in = IW'(v);
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus0.busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_digit(input int i);
        int n;
        n = 0;
        while (bus0.digit_en !== ND'(1 << i) && n < 8 * SD) begin
            tick();
            n++;
        end
        chk($sformatf("scan_idx%0d", i), 32'(bus0.digit_en), 32'(1 << i));
        chk($sformatf("scan_idx%0d_nb", i), 32'(bus1.digit_en), 32'(1 << i));
    endtask

    task automatic show(input string tag);
        for (int i = 0; i < ND; i++) begin
            wait_digit(i);
            chk($sformatf("%s_d%0d_blank", tag, i), 32'(bus0.seg), 32'(exp0[i]));
            chk($sformatf("%s_d%0d_noblank", tag, i), 32'(bus1.seg), 32'(exp1[i]));
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_busy_nb", 32'(bus1.busy), 32'd0);
        chk("rst_ovf", 32'(bus0.overflow), 32'd0);
        chk("rst_digit_en", 32'(bus0.digit_en), 32'h1);
        chk("rst_seg", 32'(bus0.seg), 32'(P0));
        rst = 1'b0;
        repeat (4 * SD) tick();
        exp0 = '{P0, POFF, POFF, POFF};
        exp1 = '{P0, P0, P0, P0};
        show("rst_disp");

        // 1234: latency and digit order
        do_load(1234);
        chk("busy_after_load", 32'(bus0.busy), 32'd1);
        wait_done(cyc);
        chk("lat_1234", 32'(cyc), 32'd16);
        exp0 = '{P4, P3, P2, P1};
        exp1 = '{P4, P3, P2, P1};
        show("v1234");

        // 7: leading-zero blanking
        do_load(7);
        wait_done(cyc);
        chk("lat_7", 32'(cyc), 32'd16);
        exp0 = '{P7, POFF, POFF, POFF};
        exp1 = '{P7, P0, P0, P0};
        show("v7");

        // 10000: overflow -> dashes on every digit
        do_load(10000);
        wait_done(cyc);
        chk("ovf_set", 32'(bus0.overflow), 32'd1);
        chk("ovf_set_nb", 32'(bus1.overflow), 32'd1);
        exp0 = '{PDSH, PDSH, PDSH, PDSH};
        exp1 = '{PDSH, PDSH, PDSH, PDSH};
        show("v10000");

        // 9999: largest in-range value clears overflow
        do_load(9999);
        wait_done(cyc);
        chk("ovf_clr", 32'(bus0.overflow), 32'd0);
        exp0 = '{P9, P9, P9, P9};
        exp1 = '{P9, P9, P9, P9};
        show("v9999");

        // 42 then 99 while busy: second load dropped
        do_load(42);
        tick();
        value_in = IW'(99);
        load     = 1'b1;
        tick();
        load     = 1'b0;
        cyc      = 2;
        while (bus0.busy && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("lat_42_busy_load", 32'(cyc), 32'd16);
        rises     = 0;
        prev_busy = bus0.busy;
        repeat (24) begin
            tick();
            if (bus0.busy && !prev_busy) rises++;
            prev_busy = bus0.busy;
        end
        chk("busy_once", 32'(rises), 32'd0);
        exp0 = '{P2, P4, POFF, POFF};
        exp1 = '{P2, P4, P0, P0};
        show("v42");

        // 5678 aborted by reset in the fifth SHIFT cycle
        do_load(5678);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        chk("abort_ovf", 32'(bus0.overflow), 32'd0);
        rst = 1'b0;
        exp0 = '{P0, POFF, POFF, POFF};
        exp1 = '{P0, P0, P0, P0};
        show("abort");

        do_load(21);
        wait_done(cyc);
        chk("lat_21", 32'(cyc), 32'd16);
        exp0 = '{P1, P2, POFF, POFF};
        exp1 = '{P1, P2, P0, P0};
        show("v21");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
